data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//   Responder side of the MiniRISC data-memory bus handshake (bus_req / bus_grant / data_mem_rd / data_mem_wr).
//   Accepts requests from NUM_MASTERS initiators (CPU, debug port, DMA) and selects one owner by round-robin.
//   Routes the owner's address, write data and strobes to the single slave bus; inserts WAIT_CYCLES wait states.
//   Returns a one-cycle grant to the owner in the cycle the access completes.
// PARAMETERS
//   NUM_MASTERS  2  number of initiators, legal range 2..4
//   WAIT_CYCLES  0  wait states per access, legal range 0..15
// PORTS
//   clk          in   1      system clock
//   rst          in   1      synchronous, active-high reset
//   m_bus_req    in   N      per-master request, held high until that master's grant
//   m_wr         in   N      per-master write enable (data_mem_wr)
//   m_rd         in   N      per-master read enable (data_mem_rd)
//   m_addr       in   8*N    per-master address; master i occupies bits [8i+7:8i]
//   m_wr_data    in   8*N    per-master write data, same packing as m_addr
//   m_lock       in   N      per-master bus lock (used only with DATA_BUS_ARB_LOCK_EN)
//   m_bus_grant  out  N      one-hot access-complete pulse to the owner
//   s_addr       out  8      slave address
//   s_wr_data    out  8      slave write data
//   s_wr         out  1      slave write strobe, high in the grant cycle only
//   s_rd         out  1      slave read strobe, high in the grant cycle only
//   busy         out  1      high when the state is not IDLE
// BEHAVIOUR
//   Reset values: m_bus_grant=0, s_wr=0, s_rd=0, s_addr=0, s_wr_data=0, busy=0.
//   Reset state: state=IDLE, owner=0, rr_ptr=0 (master 0 has highest priority).
//   Reset is also honoured in mid-access: the access is dropped and no grant or strobe is issued.
//   States: IDLE, WAIT, GRANT.
//   IDLE: if any m_bus_req is high, the owner is the first requesting index at or after rr_ptr, modulo N.
//     Register the owner, load wcnt=WAIT_CYCLES, go to WAIT. Otherwise stay in IDLE.
//   WAIT: s_addr and s_wr_data follow the owner combinationally from the registered owner index.
//     If wcnt==0, go to GRANT; otherwise decrement wcnt.
//     If m_bus_req[owner] drops (protocol violation), go to IDLE with no strobe and no grant.
//   GRANT: m_bus_grant[owner]=1 and s_wr=m_wr[owner].
//     s_rd=m_rd[owner] & ~m_wr[owner]; when both are high, the write wins.
//     The slave samples write data at the end of this cycle. Combinational read data is valid in this cycle.
//     The master uses it with the grant, e.g. as the register write enable.
//     On exit: rr_ptr=(owner+1) mod N; go to IDLE.
//   Latency: request high in cycle t (state IDLE) gives the grant in cycle t+2+WAIT_CYCLES.
//   Throughput: one access every WAIT_CYCLES+3 cycles.
//   Requests with neither m_wr nor m_rd set complete normally: grant is issued, both strobes stay low.
//   Simultaneous requests: only the owner is served; the other requests stay pending, with no loss and no timeout.
//   Non-owner inputs are ignored outside IDLE.
//   wcnt is 4 bits wide; it saturates at 0 and never wraps.
// CONFIGURATION
//   DATA_BUS_ARB_LOCK_EN defined:
//     In GRANT, if m_lock[owner]=1 and m_bus_req[owner]=1 next cycle, skip IDLE.
//     The same owner starts a new access in the cycle after GRANT (wcnt reloaded, state WAIT) and rr_ptr is not advanced.
//     Other masters are blocked until the owner drops lock. Used for multi-byte stack push/pop.
//   DATA_BUS_ARB_LOCK_EN undefined:
//     m_lock is ignored; every access returns to IDLE and advances rr_ptr.
// TESTING
//   1. N=2, W=0: m0 read from addr 0x3C, held -> grant0 two cycles later; s_rd=1, s_addr=0x3C for one cycle only.
//   2. N=2, W=0: m0 and m1 request in the same cycle after reset -> m0 granted first, then m1.
//      rr_ptr=0 afterwards; a new simultaneous pair is again served m0 first.
//   3. W=3: m1 writes 0xA5 to 0x10 -> grant1 in cycle t+5; s_wr=1 and s_wr_data=0xA5 only in that cycle.
//   4. Owner drops m_bus_req in WAIT -> no strobe, no grant; busy=0 next cycle.
//      Assert rst in WAIT -> IDLE next cycle with all outputs 0.
//   5. m_wr=m_rd=1 -> s_wr=1, s_rd=0 in grant cycle.
//   6. With DATA_BUS_ARB_LOCK_EN, m0 locked for 3 accesses while m1 requests -> grant sequence m0,m0,m0,m1.
//      Without the macro -> m0,m1,m0,m0.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin data-memory bus arbiter with wait states; optional owner lock via DATA_BUS_ARB_LOCK_EN
module data_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_MASTERS-1:0]   m_bus_req,
  input  logic [NUM_MASTERS-1:0]   m_wr,
  input  logic [NUM_MASTERS-1:0]   m_rd,
  input  logic [8*NUM_MASTERS-1:0] m_addr,
  input  logic [8*NUM_MASTERS-1:0] m_wr_data,
  input  logic [NUM_MASTERS-1:0]   m_lock,
  output logic [NUM_MASTERS-1:0]   m_bus_grant,
  output logic [7:0]               s_addr,
  output logic [7:0]               s_wr_data,
  output logic                     s_wr,
  output logic                     s_rd,
  output logic                     busy
);
  localparam int OW = $clog2(NUM_MASTERS);
  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;
  state_t        state;
  logic [OW-1:0] owner, rr_ptr, pick, idx, nxt_ptr;
  logic [3:0]    wcnt;
  logic          grant;
  // first requester at or after rr_ptr, scanning backwards so the nearest one wins
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = OW'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (m_bus_req[idx]) pick = idx;
    end
  end
  assign nxt_ptr     = (owner == OW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
  assign busy        = state != IDLE;
  assign grant       = state == GRANT;
  assign m_bus_grant = grant ? NUM_MASTERS'(1) << owner : '0;
  assign s_addr      = busy ? m_addr[{owner, 3'b000} +: 8] : '0;
  assign s_wr_data   = busy ? m_wr_data[{owner, 3'b000} +: 8] : '0;
  assign s_wr        = grant & m_wr[owner];
  assign s_rd        = grant & m_rd[owner] & ~m_wr[owner];
`ifdef DATA_BUS_ARB_LOCK_EN
  logic locked;
  // access sequencing; a locked owner chains straight into its next access
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      wcnt   <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          locked <= 1'b0;
          if (|m_bus_req) begin
            owner <= pick;
            wcnt  <= 4'(WAIT_CYCLES);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!m_bus_req[owner]) begin
            state <= IDLE;
            if (locked) rr_ptr <= nxt_ptr;
          end else if (wcnt == 4'd0) state <= GRANT;
          else wcnt <= wcnt - 1'b1;
        end
        GRANT: begin
          if (m_lock[owner]) begin
            state  <= WAIT;
            wcnt   <= 4'(WAIT_CYCLES);
            locked <= 1'b1;
          end else begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  // access sequencing: IDLE -> WAIT (wcnt wait states) -> GRANT -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      wcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_bus_req) begin
            owner <= pick;
            wcnt  <= 4'(WAIT_CYCLES);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!m_bus_req[owner]) state <= IDLE;
          else if (wcnt == 4'd0) state <= GRANT;
          else wcnt <= wcnt - 1'b1;
        end
        GRANT: begin
          state  <= IDLE;
          rr_ptr <= nxt_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed vector table plus multi-cycle sequences for data_bus_arbiter
module tb_data_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0]  req0 = '0, wr0 = '0, rd0 = '0, lock0 = '0, g0;
  logic [15:0] addr0 = '0, wd0 = '0;
  logic [7:0]  sa0, swd0;
  logic        swr0, srd0, busy0;
  logic [2:0]  req1 = '0, wr1 = '0, rd1 = '0, lock1 = '0, g1;
  logic [23:0] addr1 = '0, wd1 = '0;
  logic [7:0]  sa1, swd1;
  logic        swr1, srd1, busy1;
  int n_checks = 0, n_fail = 0;
  data_bus_arbiter #(.NUM_MASTERS(2), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .m_bus_req(req0), .m_wr(wr0), .m_rd(rd0), .m_addr(addr0),
    .m_wr_data(wd0), .m_lock(lock0), .m_bus_grant(g0), .s_addr(sa0), .s_wr_data(swd0),
    .s_wr(swr0), .s_rd(srd0), .busy(busy0));
  data_bus_arbiter #(.NUM_MASTERS(3), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .m_bus_req(req1), .m_wr(wr1), .m_rd(rd1), .m_addr(addr1),
    .m_wr_data(wd1), .m_lock(lock1), .m_bus_grant(g1), .s_addr(sa1), .s_wr_data(swd1),
    .s_wr(swr1), .s_rd(srd1), .busy(busy1));
  typedef struct {
    logic r; logic [1:0] req, wr, rd; logic [7:0] a0, a1, d0, d1;
    logic [1:0] eg; logic ews, ers; logic [7:0] ea, ed; logic eb;
  } vec_t;
  vec_t tbl[32];
  function automatic vec_t mk(logic r, logic [1:0] req, wr, rd, logic [7:0] a0, a1, d0, d1,
                              logic [1:0] eg, logic ews, ers, logic [7:0] ea, ed, logic eb);
    mk = '{r, req, wr, rd, a0, a1, d0, d1, eg, ews, ers, ea, ed, eb};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic wait_grant1();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (g1 != 3'b000) return;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    int seq[4];
    int exp_seq[4];
    int ns, m0c;
    logic [1:0] g;
    tbl[0]  = mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 2'b01, 2'b00, 2'b01, 8'h3C, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[2]  = mk(0, 2'b01, 2'b00, 2'b01, 8'h3C, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h3C, 8'h00, 1);
    tbl[3]  = mk(0, 2'b01, 2'b00, 2'b01, 8'h3C, 8'h00, 8'h00, 8'h00, 2'b01, 0, 1, 8'h3C, 8'h00, 1);
    tbl[4]  = mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[5]  = mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[6]  = mk(0, 2'b11, 2'b00, 2'b11, 8'h11, 8'h22, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[7]  = mk(0, 2'b11, 2'b00, 2'b11, 8'h11, 8'h22, 8'h00, 8'h00, 2'b00, 0, 0, 8'h11, 8'h00, 1);
    tbl[8]  = mk(0, 2'b11, 2'b00, 2'b11, 8'h11, 8'h22, 8'h00, 8'h00, 2'b01, 0, 1, 8'h11, 8'h00, 1);
    tbl[9]  = mk(0, 2'b10, 2'b00, 2'b11, 8'h11, 8'h22, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[10] = mk(0, 2'b10, 2'b00, 2'b11, 8'h11, 8'h22, 8'h00, 8'h00, 2'b00, 0, 0, 8'h22, 8'h00, 1);
    tbl[11] = mk(0, 2'b10, 2'b00, 2'b11, 8'h11, 8'h22, 8'h00, 8'h00, 2'b10, 0, 1, 8'h22, 8'h00, 1);
    tbl[12] = mk(0, 2'b11, 2'b00, 2'b11, 8'h33, 8'h44, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[13] = mk(0, 2'b11, 2'b00, 2'b11, 8'h33, 8'h44, 8'h00, 8'h00, 2'b00, 0, 0, 8'h33, 8'h00, 1);
    tbl[14] = mk(0, 2'b11, 2'b00, 2'b11, 8'h33, 8'h44, 8'h00, 8'h00, 2'b01, 0, 1, 8'h33, 8'h00, 1);
    tbl[15] = mk(0, 2'b10, 2'b00, 2'b11, 8'h33, 8'h44, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[16] = mk(0, 2'b10, 2'b00, 2'b11, 8'h33, 8'h44, 8'h00, 8'h00, 2'b00, 0, 0, 8'h44, 8'h00, 1);
    tbl[17] = mk(0, 2'b10, 2'b00, 2'b11, 8'h33, 8'h44, 8'h00, 8'h00, 2'b10, 0, 1, 8'h44, 8'h00, 1);
    tbl[18] = mk(0, 2'b01, 2'b01, 2'b00, 8'h55, 8'h00, 8'h66, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[19] = mk(0, 2'b00, 2'b01, 2'b00, 8'h55, 8'h00, 8'h66, 8'h00, 2'b00, 0, 0, 8'h55, 8'h66, 1);
    tbl[20] = mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[21] = mk(0, 2'b01, 2'b01, 2'b00, 8'h77, 8'h00, 8'h88, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[22] = mk(1, 2'b01, 2'b01, 2'b00, 8'h77, 8'h00, 8'h88, 8'h00, 2'b00, 0, 0, 8'h77, 8'h88, 1);
    tbl[23] = mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[24] = mk(0, 2'b01, 2'b01, 2'b01, 8'h9A, 8'h00, 8'hBC, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[25] = mk(0, 2'b01, 2'b01, 2'b01, 8'h9A, 8'h00, 8'hBC, 8'h00, 2'b00, 0, 0, 8'h9A, 8'hBC, 1);
    tbl[26] = mk(0, 2'b01, 2'b01, 2'b01, 8'h9A, 8'h00, 8'hBC, 8'h00, 2'b01, 1, 0, 8'h9A, 8'hBC, 1);
    tbl[27] = mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[28] = mk(0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h5A, 8'h00, 8'h0F, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    tbl[29] = mk(0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h5A, 8'h00, 8'h0F, 2'b00, 0, 0, 8'h5A, 8'h0F, 1);
    tbl[30] = mk(0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h5A, 8'h00, 8'h0F, 2'b10, 0, 0, 8'h5A, 8'h0F, 1);
    tbl[31] = mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].r; req0 = tbl[i].req; wr0 = tbl[i].wr; rd0 = tbl[i].rd;
      addr0 = {tbl[i].a1, tbl[i].a0}; wd0 = {tbl[i].d1, tbl[i].d0};
      @(negedge clk);
      check($sformatf("vec%0d {grant,s_wr,s_rd,s_addr,s_wr_data,busy}", i),
            {g0, swr0, srd0, sa0, swd0, busy0},
            {tbl[i].eg, tbl[i].ews, tbl[i].ers, tbl[i].ea, tbl[i].ed, tbl[i].eb});
    end
    @(posedge clk); #1;
    req1 = 3'b010; wr1 = 3'b010; addr1 = 24'h001000; wd1 = 24'h00A500;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("w3 grant c%0d", c), g1, c == 5 ? 3'b010 : 3'b000);
      check($sformatf("w3 s_wr c%0d", c), swr1, c == 5);
      check($sformatf("w3 s_wr_data c%0d", c), swd1, (c >= 1 && c <= 5) ? 8'hA5 : 8'h00);
      check($sformatf("w3 busy c%0d", c), busy1, c >= 1 && c <= 5);
      if (c == 5) check("w3 s_addr", sa1, 8'h10);
      @(posedge clk); #1;
      if (c == 5) begin
        req1 = '0; wr1 = '0;
      end
    end
    req1 = 3'b101; rd1 = 3'b101; addr1 = 24'hC0B0A0;
    wait_grant1();
    check("rr wrap first grant", g1, 3'b100);
    check("rr wrap first s_addr", sa1, 8'hC0);
    @(posedge clk); #1;
    req1 = 3'b001;
    wait_grant1();
    check("rr wrap second grant", g1, 3'b001);
    check("rr wrap second s_addr", sa1, 8'hA0);
    @(posedge clk); #1;
    req1 = '0; rd1 = '0;
`ifdef DATA_BUS_ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 0};
`endif
    seq = '{-1, -1, -1, -1};
    ns = 0; m0c = 0;
    @(posedge clk); #1;
    req0 = 2'b11; rd0 = 2'b11; wr0 = 2'b00; lock0 = 2'b01; addr0 = 16'h2010;
    for (int k = 0; k < 60 && ns < 4; k++) begin
      @(negedge clk);
      g = g0;
      if (g != 2'b00) begin
        seq[ns] = g[1] ? 1 : 0;
        ns++;
      end
      @(posedge clk); #1;
      if (g[0]) begin
        m0c++;
        if (m0c == 2) lock0 = 2'b00;
        if (m0c == 3) req0[0] = 1'b0;
      end
      if (g[1]) req0[1] = 1'b0;
    end
    check("lock grant count", ns, 4);
    for (int i = 0; i < 4; i++) check($sformatf("lock grant seq[%0d]", i), seq[i], exp_seq[i]);
    req0 = '0; rd0 = '0; lock0 = '0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
